// File: rtl/reloj_digit_buffer.sv
// ============================================================================
// reloj_digit_buffer: double-buffered BCD digit bank published on the vsync edge
// Optional macro: RELOJ_BCD_CHECK_EN (reject non-BCD digit writes). Revision 1.0
// ============================================================================
`default_nettype none

module reloj_digit_buffer #(
    parameter int VSYNC_ACTIVE_LOW = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_en,
    output logic        wr_ready,
    input  logic [3:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        commit,
    input  logic        vsync,
    output logic [23:0] time_digits,
    output logic [23:0] date_digits,
    output logic [23:0] timer_digits,
    output logic        am_pm,
    output logic        formato_hora,
    output logic        estado_alarma,
    output logic        frame_updated,
    output logic        bcd_err
);

    localparam logic       c_VSYNC_IDLE     = (VSYNC_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam int         c_NUM_DIGIT_REGS = 9;
    localparam logic [3:0] c_CTRL_ADDR      = 4'd9;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t     r_state;
    logic [7:0] r_stage [0:c_NUM_DIGIT_REGS-1];
    logic [2:0] r_stage_ctrl;
    logic       r_vsync_d;
    logic       w_swap_edge;
    logic       w_wr_fire;
    logic       w_wr_drop;

    // The swap fires on the transition into the active vsync level.
    assign w_swap_edge = (VSYNC_ACTIVE_LOW != 0) ? (r_vsync_d & ~vsync) : (~r_vsync_d & vsync);
    assign wr_ready    = (r_state == IDLE);
    assign w_wr_fire   = wr_en & wr_ready;

`ifdef RELOJ_BCD_CHECK_EN
    logic r_bcd_err;

    assign w_wr_drop = (wr_addr < c_CTRL_ADDR) &&
                       ((wr_data[7:4] > 4'd9) || (wr_data[3:0] > 4'd9));
    assign bcd_err   = r_bcd_err;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_bcd_err <= 1'b0;
        end else if (w_wr_fire && w_wr_drop) begin
            r_bcd_err <= 1'b1;
        end
    end
`else
    assign w_wr_drop = 1'b0;
    assign bcd_err   = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_vsync_d     <= c_VSYNC_IDLE;
            r_stage_ctrl  <= 3'd0;
            time_digits   <= 24'd0;
            date_digits   <= 24'd0;
            timer_digits  <= 24'd0;
            am_pm         <= 1'b0;
            formato_hora  <= 1'b0;
            estado_alarma <= 1'b0;
            frame_updated <= 1'b0;
            for (int i = 0; i < c_NUM_DIGIT_REGS; i++) begin
                r_stage[i] <= 8'd0;
            end
        end else begin
            r_vsync_d     <= vsync;
            frame_updated <= 1'b0;

            // Writes only happen in IDLE, so they never race a swap.
            if (w_wr_fire && !w_wr_drop) begin
                for (int i = 0; i < c_NUM_DIGIT_REGS; i++) begin
                    if (wr_addr == 4'(i)) begin
                        r_stage[i] <= wr_data;
                    end
                end
                if (wr_addr == c_CTRL_ADDR) begin
                    r_stage_ctrl <= wr_data[2:0];
                end
            end

            case (r_state)
                IDLE: begin
                    if (commit) begin
                        r_state <= ARMED;
                    end
                end
                ARMED: begin
                    if (w_swap_edge) begin
                        time_digits   <= {r_stage[2], r_stage[1], r_stage[0]};
                        date_digits   <= {r_stage[3], r_stage[4], r_stage[5]};
                        timer_digits  <= {r_stage[8], r_stage[7], r_stage[6]};
                        am_pm         <= r_stage_ctrl[0];
                        formato_hora  <= r_stage_ctrl[1];
                        estado_alarma <= r_stage_ctrl[2];
                        frame_updated <= 1'b1;
                        r_state       <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reloj_digit_buffer.sv
// ============================================================================
// tb_reloj_digit_buffer: directed and random checks against a register-bank model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_reloj_digit_buffer;

`ifdef RELOJ_BCD_CHECK_EN
    localparam bit c_CHECK = 1'b1;
`else
    localparam bit c_CHECK = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = 4'd0;
    logic [7:0]  wr_data = 8'd0;
    logic        commit = 1'b0;
    logic        vsync = 1'b1;
    logic        wr_ready;
    logic [23:0] time_digits;
    logic [23:0] date_digits;
    logic [23:0] timer_digits;
    logic        am_pm;
    logic        formato_hora;
    logic        estado_alarma;
    logic        frame_updated;
    logic        bcd_err;

    reloj_digit_buffer #(.VSYNC_ACTIVE_LOW(1)) dut (
        .clock         (clock),
        .reset         (reset),
        .wr_en         (wr_en),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .commit        (commit),
        .vsync         (vsync),
        .time_digits   (time_digits),
        .date_digits   (date_digits),
        .timer_digits  (timer_digits),
        .am_pm         (am_pm),
        .formato_hora  (formato_hora),
        .estado_alarma (estado_alarma),
        .frame_updated (frame_updated),
        .bcd_err       (bcd_err)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: staged and displayed byte arrays indexed by address.
    logic [7:0] m_stage [0:8];
    logic [7:0] m_disp  [0:8];
    logic [2:0] m_sctrl;
    logic [2:0] m_dctrl;
    logic       m_pending;
    logic       m_fu;
    logic       m_err;
    logic       m_vprev;

    function automatic bit bad_bcd(input logic [7:0] d);
        return (d[7:4] > 4'd9) || (d[3:0] > 4'd9);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 9; i++) begin
            m_stage[i] = 8'd0;
            m_disp[i]  = 8'd0;
        end
        m_sctrl   = 3'd0;
        m_dctrl   = 3'd0;
        m_pending = 1'b0;
        m_fu      = 1'b0;
        m_err     = 1'b0;
        m_vprev   = 1'b1;
    endtask

    task automatic model_edge();
        logic fire;
        logic fall;
        logic was_pending;
        fire        = wr_en && !m_pending;
        fall        = m_vprev && !vsync;
        was_pending = m_pending;
        m_fu        = 1'b0;
        if (was_pending && fall) begin
            for (int i = 0; i < 9; i++) m_disp[i] = m_stage[i];
            m_dctrl   = m_sctrl;
            m_pending = 1'b0;
            m_fu      = 1'b1;
        end
        if (fire) begin
            if (wr_addr < 4'd9) begin
                if (c_CHECK && bad_bcd(wr_data)) m_err = 1'b1;
                else m_stage[wr_addr] = wr_data;
            end else if (wr_addr == 4'd9) begin
                m_sctrl = wr_data[2:0];
            end
        end
        if (commit && !was_pending) m_pending = 1'b1;
        m_vprev = vsync;
    endtask

    task automatic check_all();
        chk("time",  time_digits,  {m_disp[2], m_disp[1], m_disp[0]});
        chk("date",  date_digits,  {m_disp[3], m_disp[4], m_disp[5]});
        chk("timer", timer_digits, {m_disp[8], m_disp[7], m_disp[6]});
        chk("flags", {estado_alarma, formato_hora, am_pm}, m_dctrl);
        chk("wr_ready", wr_ready, !m_pending);
        chk("frame_updated", frame_updated, m_fu);
        chk("bcd_err", bcd_err, m_err);
    endtask

    task automatic cycle();
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        cycle();
        wr_en = 1'b0;
    endtask

    // Commit, one idle-high cycle, then a falling vsync; returns just after the swap edge.
    task automatic publish();
        commit = 1'b1; vsync = 1'b1;
        cycle();
        commit = 1'b0;
        cycle();
        vsync = 1'b0;
        cycle();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        vsync = 1'b1;
        apply_reset();
        chk("rst_ready", wr_ready, 1'b1);
        chk("rst_time", time_digits, 24'h000000);

        // Basic publish of a time value.
        wr(4'd2, 8'h12);
        wr(4'd1, 8'h34);
        wr(4'd0, 8'h56);
        publish();
        chk("tp1_time", time_digits, 24'h123456);
        chk("tp1_fu", frame_updated, 1'b1);
        chk("tp1_ready", wr_ready, 1'b1);
        vsync = 1'b1;
        cycle();
        chk("tp1_fu_pulse", frame_updated, 1'b0);

        // Long frame while armed: writes are refused and outputs hold.
        commit = 1'b1;
        cycle();
        commit = 1'b0;
        chk("hold_ready_low", wr_ready, 1'b0);
        repeat (1000) begin
            wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h99;
            cycle();
        end
        wr_en = 1'b0;
        chk("hold_time", time_digits, 24'h123456);
        chk("hold_ready", wr_ready, 1'b0);
        vsync = 1'b0;
        cycle();
        chk("hold_fu", frame_updated, 1'b1);
        chk("hold_time_after", time_digits, 24'h123456);
        vsync = 1'b1;
        wr(4'd0, 8'h21);
        publish();
        chk("post_hold_time", time_digits, 24'h123421);

        // Commit coinciding with the edge arms but does not publish this frame.
        vsync = 1'b1;
        wr(4'd1, 8'h45);
        commit = 1'b1; vsync = 1'b0;
        cycle();
        commit = 1'b0;
        chk("same_edge_fu", frame_updated, 1'b0);
        chk("same_edge_armed", wr_ready, 1'b0);
        cycle();
        chk("same_edge_time", time_digits, 24'h123421);
        vsync = 1'b1;
        cycle();
        vsync = 1'b0;
        cycle();
        chk("next_edge_fu", frame_updated, 1'b1);
        chk("next_edge_time", time_digits, 24'h124521);

        // Control byte and a write to an unused address.
        vsync = 1'b1;
        wr(4'd9, 8'h07);
        publish();
        chk("ctrl_flags", {estado_alarma, formato_hora, am_pm}, 3'b111);
        vsync = 1'b1;
        wr(4'd12, 8'hFF);
        publish();
        chk("unused_flags", {estado_alarma, formato_hora, am_pm}, 3'b111);
        chk("unused_time", time_digits, 24'h124521);
        chk("unused_date", date_digits, 24'h000000);

        // Non-BCD digit byte.
        vsync = 1'b1;
        wr(4'd3, 8'h3A);
        chk("bcd_err_flag", bcd_err, c_CHECK);
        publish();
        chk("bcd_day", date_digits[23:16], c_CHECK ? 8'h00 : 8'h3A);

        // Reset while armed drops the pending commit.
        vsync = 1'b1;
        wr(4'd8, 8'h23);
        commit = 1'b1;
        cycle();
        commit = 1'b0;
        chk("pre_reset_armed", wr_ready, 1'b0);
        apply_reset();
        chk("reset_time", time_digits, 24'h000000);
        chk("reset_ready", wr_ready, 1'b1);
        cycle();
        vsync = 1'b0;
        cycle();
        chk("reset_no_swap", frame_updated, 1'b0);
        vsync = 1'b1;
        cycle();

        // Random traffic against the model.
        repeat (3000) begin
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) wr_data = 8'($urandom_range(0, 255));
            else wr_data = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            commit  = ($urandom_range(0, 9) == 0);
            vsync   = ($urandom_range(0, 5) != 0);
            cycle();
        end
        wr_en = 1'b0; commit = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
